cart_mem_bridge: RTL

Sits between the core's cartridge port and the board SDRAM controller. It turns cart fetch pulses (`cart_read`/`cart_addr_out` from the core) into SDRAM word requests and returns the selected byte on `cart_dout`, which feeds the core's `cart_out`. A one-word read buffer serves repeat hits without touching SDRAM. During ROM download it also carries the loader's byte writes into SDRAM.

---
 rtl/cart_mem_bridge_if.sv | 20 ++
 rtl/cart_mem_bridge.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cart_mem_bridge_if.sv
// SDRAM-controller side of the cartridge bridge: one request/ack word port.
interface cart_mem_bridge_if;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cart_mem_bridge.sv
// Cartridge fetch / ROM download bridge to the SDRAM controller.
// A one-word read buffer serves repeat fetches; misses and loader byte
// writes become single SDRAM word requests held until acknowledged.
module cart_mem_bridge #(
  parameter int DEADLINE = 12
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  cart_read,
  input  logic [24:0]           cart_addr,
  output logic [7:0]            cart_dout,
  output logic                  rd_valid,
  input  logic                  loading,
  input  logic                  dl_wr,
  input  logic [24:0]           dl_addr,
  input  logic [7:0]            dl_data,
  output logic                  dl_wait,
  cart_mem_bridge_if.master     mem,
  output logic                  overrun,
  output logic                  late
);

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ} state_t;

  // Ages count cycles since a fetch was accepted; they saturate at the
  // deadline because late is sticky once that age is reached.
  localparam int              AGE_W     = $clog2(DEADLINE + 2);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(DEADLINE);

  state_t            state_reg;
  logic [23:0]       buf_tag_reg;
  logic [15:0]       buf_data_reg;
  logic              buf_valid_reg;
  logic              pend_valid_reg;
  logic [24:0]       pend_addr_reg;
  logic [AGE_W-1:0]  pend_age_reg;
  logic              act_trk_reg;
  logic [AGE_W-1:0]  act_age_reg;
  logic              rd_sel_reg;
  logic              loading_d_reg;

  logic              new_read;
  logic              svc_valid;
  logic              svc_hit;
  logic [24:0]       svc_addr;
  logic [AGE_W-1:0]  svc_age;
  logic              wr_accept;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a < AGE_LIMIT) ? a + 1'b1 : a;
  endfunction

  // Pick the fetch to service this cycle (pending beats new) and arbitrate writes.
  always_comb begin
    new_read  = cart_read & ~loading;
    svc_valid = 1'b0;
    svc_addr  = cart_addr;
    svc_age   = '0;
    if (state_reg == IDLE) begin
      if (pend_valid_reg) begin
        svc_valid = 1'b1;
        svc_addr  = pend_addr_reg;
        svc_age   = pend_age_reg;
      end else if (new_read) begin
        svc_valid = 1'b1;
      end
    end
    svc_hit   = svc_valid & buf_valid_reg & (buf_tag_reg == svc_addr[24:1]);
    dl_wait   = (state_reg != IDLE) | pend_valid_reg | new_read;
    wr_accept = dl_wr & ~dl_wait;
  end

  // Request FSM, read buffer, pending slot and sticky status flags.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_reg      <= IDLE;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_be     <= 2'b00;
      mem.mem_wdata  <= '0;
      cart_dout      <= 8'hFF;
      rd_valid       <= 1'b0;
      overrun        <= 1'b0;
      late           <= 1'b0;
      buf_tag_reg    <= '0;
      buf_data_reg   <= '0;
      buf_valid_reg  <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      pend_age_reg   <= '0;
      act_trk_reg    <= 1'b0;
      act_age_reg    <= '0;
      rd_sel_reg     <= 1'b0;
      loading_d_reg  <= 1'b0;
    end else begin
      rd_valid      <= 1'b0;
      loading_d_reg <= loading;

      if (pend_valid_reg) pend_age_reg <= age_inc(pend_age_reg);
      if (act_trk_reg)    act_age_reg  <= age_inc(act_age_reg);
      if ((act_trk_reg && act_age_reg == AGE_LIMIT) ||
          (pend_valid_reg && pend_age_reg == AGE_LIMIT))
        late <= 1'b1;

      // A fetch arriving while busy waits in the single pending slot.
      if (new_read && state_reg != IDLE) begin
        pend_valid_reg <= 1'b1;
        pend_addr_reg  <= cart_addr;
        pend_age_reg   <= AGE_W'(1);
        if (pend_valid_reg) overrun <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (svc_valid) begin
            // Servicing the pending slot frees it; a simultaneous new fetch refills it.
            if (pend_valid_reg) begin
              if (new_read) begin
                pend_addr_reg <= cart_addr;
                pend_age_reg  <= AGE_W'(1);
              end else begin
                pend_valid_reg <= 1'b0;
              end
            end
            if (svc_hit) begin
              cart_dout <= svc_addr[0] ? buf_data_reg[15:8] : buf_data_reg[7:0];
              rd_valid  <= 1'b1;
            end else begin
              state_reg     <= RD_REQ;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= 1'b0;
              mem.mem_addr  <= svc_addr[24:1];
              mem.mem_be    <= 2'b11;
              rd_sel_reg    <= svc_addr[0];
              act_trk_reg   <= 1'b1;
              act_age_reg   <= age_inc(svc_age);
            end
          end else if (wr_accept) begin
            state_reg     <= WR_REQ;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= dl_addr[24:1];
            mem.mem_be    <= dl_addr[0] ? 2'b10 : 2'b01;
            mem.mem_wdata <= {dl_data, dl_data};
            buf_valid_reg <= 1'b0;
          end
        end
        RD_REQ: begin
          if (mem.mem_ack) begin
            state_reg     <= IDLE;
            mem.mem_req   <= 1'b0;
            buf_tag_reg   <= mem.mem_addr;
            buf_data_reg  <= mem.mem_rdata;
            buf_valid_reg <= 1'b1;
            cart_dout     <= rd_sel_reg ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
            rd_valid      <= 1'b1;
            act_trk_reg   <= 1'b0;
          end
        end
        WR_REQ: begin
          if (mem.mem_ack) begin
            state_reg   <= IDLE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A new ROM download makes any buffered word stale.
      if (loading && !loading_d_reg) buf_valid_reg <= 1'b0;
    end
  end

endmodule
